// File: rtl/stopwatch.sv
// ============================================================================
// Module   : stopwatch
// Brief    : Counts clock cycles from a start pulse to a stop pulse and holds
//            the result under a valid/ready handshake. Optional lap sampling
//            is compiled in when STOPWATCH_LAP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  output logic [W-1:0] value,
  output logic         valid,
  input  logic         ready,
  output logic         busy,
  output logic         over
`ifdef STOPWATCH_LAP_EN
  ,
  input  logic         lap,
  output logic [W-1:0] lap_value,
  output logic         lap_valid
`endif
);

  localparam logic [W-1:0] c_max = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [W-1:0] r_count;
  logic [W-1:0] r_value;
  logic         r_over;
  logic         w_sat;
  logic [W-1:0] w_count_inc;

  // The interval ending at this edge is count+1, clamped at the top code.
  assign w_sat       = (r_count == c_max);
  assign w_count_inc = w_sat ? r_count : r_count + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_RUN;
      S_RUN:  if (stop)  w_next = S_DONE;
      S_DONE: if (ready) w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_value <= '0;
      r_over  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_count <= '0;
            r_over  <= 1'b0;
          end
        end
        S_RUN: begin
          if (stop) begin
            r_value <= w_count_inc;
            r_over  <= r_over | w_sat;
          end else if (start) begin
            r_count <= '0;
            r_over  <= 1'b0;
          end else begin
            r_count <= w_count_inc;
            if (w_sat) r_over <= 1'b1;
          end
        end
        S_DONE: begin
          // Result and overflow stay frozen until the consumer takes them.
          if (ready && start) begin
            r_count <= '0;
            r_over  <= 1'b0;
          end
        end
        default: begin
          r_count <= '0;
        end
      endcase
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [W-1:0] r_lap_value;
  logic         r_lap_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lap_value <= '0;
      r_lap_valid <= 1'b0;
    end else begin
      r_lap_valid <= 1'b0;
      if (lap && r_state == S_RUN) begin
        r_lap_value <= w_count_inc;
        r_lap_valid <= 1'b1;
      end
    end
  end

  assign lap_value = r_lap_value;
  assign lap_valid = r_lap_valid;
`endif

  assign value = r_value;
  assign over  = r_over;
  assign busy  = (r_state == S_RUN);
  assign valid = (r_state == S_DONE);

endmodule

`default_nettype wire
